// File: rtl/inst_fetch_queue.sv
// Decoupled instruction fetch stage.
// Issues one icache request at a time and tags each accepted response with its address and
// compressed-instruction flag. Responses are buffered in a DEPTH-entry FIFO that the
// decoder/issue stage drains. A ROB clear redirects fetch and empties the queue.
//
// Handshakes:
//   icache request : start_fetch is a registered valid. pc holds steady until a response is
//                    accepted. A response is accepted when
//                    fetch_ready && start_fetch && inst_addr == pc.
//                    Any other response is stale and is dropped.
//   decoder side   : out_valid is the head-valid. issue_signal acts as the consumer's ready/pop.
//                    It only takes effect when out_valid is high. There is no bypass, so a
//                    pushed word appears on out_* one cycle after its acceptance.
module inst_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   rob_clear_up,
  input  logic [31:0]            rob_next_pc,
  output logic [31:0]            pc,
  output logic                   start_fetch,
  input  logic                   fetch_ready,
  input  logic [31:0]            inst,
  input  logic [31:0]            inst_addr,
  output logic [31:0]            pred_pc,
  input  logic [31:0]            pred_next_pc,
  output logic                   out_valid,
  output logic [31:0]            out_inst,
  output logic [31:0]            out_addr,
  output logic                   out_is_c,
  input  logic                   issue_signal,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] addr;
    logic        is_c;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic            accept;
  logic            do_pop;
  logic            wr_en;
  logic [CW-1:0]   count_nxt;
  entry_t          head_e;

  // The predictor looks up the address of the word currently returning from the icache.
  assign pred_pc = inst_addr;

  // Accept/pop qualification and next occupancy for the normal (non-flush) path.
  always_comb begin
    accept    = fetch_ready && start_fetch && (inst_addr == pc);
    do_pop    = issue_signal && (count != '0);
    count_nxt = count;
    if (accept && !do_pop) begin
      count_nxt = count + CW'(1);
    end else if (!accept && do_pop) begin
      count_nxt = count - CW'(1);
    end
  end

  // A push only lands when the stage is running and not being flushed.
  assign wr_en = !rst_in && rdy_in && !rob_clear_up && accept;

  // Head-of-queue view. An empty queue presents zeros instead of stale storage.
  always_comb begin
    head_e    = mem[head];
    out_valid = (count != '0);
    out_inst  = out_valid ? head_e.word : 32'h0;
    out_addr  = out_valid ? head_e.addr : 32'h0;
    out_is_c  = out_valid ? head_e.is_c : 1'b0;
  end

  // Queue storage write. A word whose low two bits are not 2'b11 is an RVC instruction.
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      mem[tail] <= '{word: inst, addr: inst_addr, is_c: (inst[1:0] != 2'b11)};
    end
  end

  // Fetch PC, request valid and queue pointers.
  // Priority: reset > stall > flush > normal.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pc          <= RESET_PC;
      start_fetch <= 1'b1;
      count       <= '0;
      head        <= '0;
      tail        <= '0;
    end else if (rdy_in) begin
      if (rob_clear_up) begin
        pc          <= rob_next_pc;
        start_fetch <= 1'b1;
        count       <= '0;
        head        <= '0;
        tail        <= '0;
      end else begin
        if (accept) begin
          tail <= tail + PW'(1);
          pc   <= pred_next_pc;
        end
        if (do_pop) begin
          head <= head + PW'(1);
        end
        count <= count_nxt;
        // The request is re-evaluated after an accept, and while parked because the queue was full.
        if (accept || !start_fetch) begin
          start_fetch <= (count_nxt < CW'(DEPTH));
        end
      end
    end
  end

  // Simulation guard: a push into a full queue with no simultaneous pop must never happen.
  always @(posedge clk_in) begin
    if (!rst_in && rdy_in && !rob_clear_up && accept && !do_pop) begin
      assert (count != CW'(DEPTH))
        else $fatal(1, "inst_fetch_queue: push into full queue");
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue (DEPTH=4, RESET_PC=0).
module tb_inst_fetch_queue;

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic        rob_clear_up;
  logic [31:0] rob_next_pc;
  logic [31:0] pc;
  logic        start_fetch;
  logic        fetch_ready;
  logic [31:0] inst;
  logic [31:0] inst_addr;
  logic [31:0] pred_pc;
  logic [31:0] pred_next_pc;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_addr;
  logic        out_is_c;
  logic        issue_signal;
  logic [2:0]  count;

  int          n_cmp;
  int          n_fail;
  logic [31:0] exp_pc;
  logic [31:0] exp_q[$];

  inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .rdy_in       (rdy_in),
    .rob_clear_up (rob_clear_up),
    .rob_next_pc  (rob_next_pc),
    .pc           (pc),
    .start_fetch  (start_fetch),
    .fetch_ready  (fetch_ready),
    .inst         (inst),
    .inst_addr    (inst_addr),
    .pred_pc      (pred_pc),
    .pred_next_pc (pred_next_pc),
    .out_valid    (out_valid),
    .out_inst     (out_inst),
    .out_addr     (out_addr),
    .out_is_c     (out_is_c),
    .issue_signal (issue_signal),
    .count        (count)
  );

  // Clock / reset block
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic respond(input logic [31:0] a, input logic [31:0] w,
                         input logic [31:0] p, input logic iss);
    fetch_ready  = 1'b1;
    inst_addr    = a;
    inst         = w;
    pred_next_pc = p;
    issue_signal = iss;
    tick();
    fetch_ready  = 1'b0;
    issue_signal = 1'b0;
  endtask

  task automatic pop_one();
    issue_signal = 1'b1;
    tick();
    issue_signal = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b1; rdy_in = 1'b1; rob_clear_up = 1'b0; rob_next_pc = 32'h0;
    fetch_ready = 1'b0; inst = 32'h0; inst_addr = 32'h0; pred_next_pc = 32'h0;
    issue_signal = 1'b0;
    tick(); tick();
    rst_in = 1'b0;
    n_cmp++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h0); end
    n_cmp++; if (start_fetch !== 1'b1) begin n_fail++; $display("FAIL reset_start: got %b expected 1", start_fetch); end
    n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    n_cmp++; if (out_inst !== 32'h0) begin n_fail++; $display("FAIL reset_inst: got %h expected 0", out_inst); end
    exp_pc = 32'h0;
  endtask

  task automatic test_basic();
    fetch_ready = 1'b1; inst_addr = 32'h0; inst = 32'h00000013; pred_next_pc = 32'h4;
    #1;
    n_cmp++; if (pred_pc !== 32'h0) begin n_fail++; $display("FAIL basic_pred_pc: got %h expected 0", pred_pc); end
    inst_addr = 32'h0;
    tick();
    fetch_ready = 1'b0;
    exp_pc = 32'h4;
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b expected 1", out_valid); end
    n_cmp++; if (out_addr !== 32'h0) begin n_fail++; $display("FAIL basic_addr: got %h expected 0", out_addr); end
    n_cmp++; if (out_inst !== 32'h00000013) begin n_fail++; $display("FAIL basic_inst: got %h expected 00000013", out_inst); end
    n_cmp++; if (out_is_c !== 1'b0) begin n_fail++; $display("FAIL basic_is_c: got %b expected 0", out_is_c); end
    n_cmp++; if (pc !== exp_pc) begin n_fail++; $display("FAIL basic_pc: got %h expected %h", pc, exp_pc); end
    n_cmp++; if (count !== 3'd1) begin n_fail++; $display("FAIL basic_count: got %0d expected 1", count); end
    pop_one();
    n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL basic_drain: got %0d expected 0", count); end
  endtask

  task automatic test_rvc();
    respond(32'h4, 32'h00000013, 32'h8, 1'b0);
    // RVC word arrives while the older entry is issued.
    respond(32'h8, 32'h00004501, 32'hA, 1'b1);
    exp_pc = 32'hA;
    n_cmp++; if (out_is_c !== 1'b1) begin n_fail++; $display("FAIL rvc_is_c: got %b expected 1", out_is_c); end
    n_cmp++; if (out_addr !== 32'h8) begin n_fail++; $display("FAIL rvc_addr: got %h expected 8", out_addr); end
    n_cmp++; if (out_inst !== 32'h00004501) begin n_fail++; $display("FAIL rvc_inst: got %h expected 00004501", out_inst); end
    n_cmp++; if (pc !== exp_pc) begin n_fail++; $display("FAIL rvc_pc: got %h expected %h", pc, exp_pc); end
    n_cmp++; if (count !== 3'd1) begin n_fail++; $display("FAIL rvc_count: got %0d expected 1", count); end
    pop_one();
  endtask

  task automatic test_fill_wrap();
    for (int i = 0; i < 4; i++) begin
      respond(exp_pc, 32'h00000013, exp_pc + 32'h4, 1'b0);
      exp_pc = exp_pc + 32'h4;
    end
    n_cmp++; if (start_fetch !== 1'b0) begin n_fail++; $display("FAIL full_start: got %b expected 0", start_fetch); end
    n_cmp++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d expected 4", count); end
    n_cmp++; if (pc !== 32'h1A) begin n_fail++; $display("FAIL full_pc: got %h expected 0000001a", pc); end
    // A response while no request is outstanding is dropped.
    respond(32'h1A, 32'h00000013, 32'h999, 1'b0);
    n_cmp++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_drop_count: got %0d expected 4", count); end
    n_cmp++; if (pc !== 32'h1A) begin n_fail++; $display("FAIL full_drop_pc: got %h expected 0000001a", pc); end
    pop_one();
    n_cmp++; if (count !== 3'd3) begin n_fail++; $display("FAIL unfull_count: got %0d expected 3", count); end
    n_cmp++; if (start_fetch !== 1'b1) begin n_fail++; $display("FAIL unfull_start: got %b expected 1", start_fetch); end
    exp_q = {32'hE, 32'h12, 32'h16};
    for (int i = 0; i < 10; i++) begin
      n_cmp++; if (out_addr !== exp_q[0]) begin n_fail++; $display("FAIL wrap_addr[%0d]: got %h expected %h", i, out_addr, exp_q[0]); end
      respond(exp_pc, 32'h00000013, exp_pc + 32'h4, 1'b1);
      void'(exp_q.pop_front());
      exp_q.push_back(exp_pc);
      exp_pc = exp_pc + 32'h4;
      n_cmp++; if (count !== 3'd3) begin n_fail++; $display("FAIL wrap_count[%0d]: got %0d expected 3", i, count); end
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (out_addr !== exp_q[0]) begin n_fail++; $display("FAIL drain_addr[%0d]: got %h expected %h", i, out_addr, exp_q[0]); end
      pop_one();
      void'(exp_q.pop_front());
    end
    n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL drain_count: got %0d expected 0", count); end
    n_cmp++; if (out_addr !== 32'h0) begin n_fail++; $display("FAIL empty_addr: got %h expected 0", out_addr); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      respond(exp_pc, 32'h00000013, exp_pc + 32'h4, 1'b0);
      exp_pc = exp_pc + 32'h4;
    end
    n_cmp++; if (count !== 3'd3) begin n_fail++; $display("FAIL flush_pre_count: got %0d expected 3", count); end
    rob_clear_up = 1'b1; rob_next_pc = 32'h100;
    fetch_ready = 1'b1; inst_addr = exp_pc; inst = 32'h00000013; pred_next_pc = 32'h999;
    issue_signal = 1'b1;
    tick();
    rob_clear_up = 1'b0; fetch_ready = 1'b0; issue_signal = 1'b0;
    n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL flush_count: got %0d expected 0", count); end
    n_cmp++; if (pc !== 32'h100) begin n_fail++; $display("FAIL flush_pc: got %h expected 00000100", pc); end
    n_cmp++; if (start_fetch !== 1'b1) begin n_fail++; $display("FAIL flush_start: got %b expected 1", start_fetch); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b expected 0", out_valid); end
    respond(32'h10, 32'h00000013, 32'h200, 1'b0);
    n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL stale_count: got %0d expected 0", count); end
    n_cmp++; if (pc !== 32'h100) begin n_fail++; $display("FAIL stale_pc: got %h expected 00000100", pc); end
    respond(32'h100, 32'h00000093, 32'h104, 1'b0);
    n_cmp++; if (count !== 3'd1) begin n_fail++; $display("FAIL redirect_count: got %0d expected 1", count); end
    n_cmp++; if (out_addr !== 32'h100) begin n_fail++; $display("FAIL redirect_addr: got %h expected 00000100", out_addr); end
    n_cmp++; if (out_inst !== 32'h00000093) begin n_fail++; $display("FAIL redirect_inst: got %h expected 00000093", out_inst); end
    n_cmp++; if (pc !== 32'h104) begin n_fail++; $display("FAIL redirect_pc: got %h expected 00000104", pc); end
    pop_one();
  endtask

  task automatic test_stall();
    respond(32'h104, 32'h00008082, 32'h108, 1'b0);
    n_cmp++; if (out_is_c !== 1'b1) begin n_fail++; $display("FAIL stall_pre_is_c: got %b expected 1", out_is_c); end
    rdy_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      fetch_ready = 1'b1; inst_addr = 32'h108; inst = 32'h00000013; pred_next_pc = 32'h500;
      issue_signal = 1'b1; rob_clear_up = 1'b1; rob_next_pc = 32'h300;
      tick();
      n_cmp++; if (count !== 3'd1) begin n_fail++; $display("FAIL stall_count[%0d]: got %0d expected 1", i, count); end
      n_cmp++; if (pc !== 32'h108) begin n_fail++; $display("FAIL stall_pc[%0d]: got %h expected 00000108", i, pc); end
      n_cmp++; if (start_fetch !== 1'b1) begin n_fail++; $display("FAIL stall_start[%0d]: got %b expected 1", i, start_fetch); end
      n_cmp++; if (out_addr !== 32'h104) begin n_fail++; $display("FAIL stall_addr[%0d]: got %h expected 00000104", i, out_addr); end
    end
    fetch_ready = 1'b0; issue_signal = 1'b0; rob_clear_up = 1'b0; rdy_in = 1'b1;
    tick();
    n_cmp++; if (count !== 3'd1) begin n_fail++; $display("FAIL stall_post_count: got %0d expected 1", count); end
    n_cmp++; if (pc !== 32'h108) begin n_fail++; $display("FAIL stall_post_pc: got %h expected 00000108", pc); end
    pop_one();
  endtask

  task automatic test_back_to_back();
    respond(32'h108, 32'h00000013, 32'h10C, 1'b0);
    respond(32'h10C, 32'h00000013, 32'h110, 1'b0);
    n_cmp++; if (count !== 3'd2) begin n_fail++; $display("FAIL b2b_pre_count: got %0d expected 2", count); end
    respond(32'h110, 32'h00000013, 32'h114, 1'b1);
    n_cmp++; if (count !== 3'd2) begin n_fail++; $display("FAIL b2b_count0: got %0d expected 2", count); end
    n_cmp++; if (out_addr !== 32'h10C) begin n_fail++; $display("FAIL b2b_addr0: got %h expected 0000010c", out_addr); end
    n_cmp++; if (pc !== 32'h114) begin n_fail++; $display("FAIL b2b_pc: got %h expected 00000114", pc); end
    respond(32'h114, 32'h00000013, 32'h118, 1'b1);
    n_cmp++; if (count !== 3'd2) begin n_fail++; $display("FAIL b2b_count1: got %0d expected 2", count); end
    n_cmp++; if (out_addr !== 32'h110) begin n_fail++; $display("FAIL b2b_addr1: got %h expected 00000110", out_addr); end
    pop_one();
    n_cmp++; if (out_addr !== 32'h114) begin n_fail++; $display("FAIL b2b_addr2: got %h expected 00000114", out_addr); end
    pop_one();
    n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL b2b_end_count: got %0d expected 0", count); end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_basic();
    test_rvc();
    test_fill_wrap();
    test_flush();
    test_stall();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
